// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes (also used by the
// instruction decoder) and FSM state encodings.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_twos_negate.sv
// Combinational conditional two's-complement negate.
module muldiv_unit_twos_negate #(
  parameter int unsigned width = 32
) (
  input  logic             negate,
  input  logic [width-1:0] value,
  output logic [width-1:0] result
);

  // Pass through, or return the two's complement when negate is set.
  always_comb begin
    result = negate ? (~value + {{(width-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on launch; one bit is processed per cycle
// in a shared 2*data_width accumulator, and the sign is restored in FIX.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned count_width = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [data_width-1:0] operand_a,
  input  logic [data_width-1:0] operand_b,
  input  logic                  hilo_write,
  input  logic                  hilo_sel,
  input  logic [data_width-1:0] hilo_write_data,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);

  md_state_e                   state_q, state_d;
  logic [count_width-1:0]      count_q, count_d;
  logic [2*data_width-1:0]     acc_q, acc_d;
  logic [data_width-1:0]       opnd_q, opnd_d;
  logic [data_width-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                        done_q, done_d;
  logic                        is_div_q, is_div_d;
  logic                        neg_lo_q, neg_lo_d;   // product / quotient sign
  logic                        neg_hi_q, neg_hi_d;   // remainder sign
  logic                        div_zero_q, div_zero_d;

  logic                        signed_op, div_op, a_neg, b_neg;
  logic [data_width-1:0]       a_mag, b_mag, quot_fix, rem_fix;
  logic [2*data_width-1:0]     prod_fix;
  logic [data_width:0]         mul_sum, div_rem, div_diff;
  logic                        div_ok;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign div_op    = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg     = signed_op & operand_a[data_width-1];
  assign b_neg     = signed_op & operand_b[data_width-1];

  muldiv_unit_twos_negate #(.width(data_width)) u_mag_a (
    .negate (a_neg),
    .value  (operand_a),
    .result (a_mag)
  );

  muldiv_unit_twos_negate #(.width(data_width)) u_mag_b (
    .negate (b_neg),
    .value  (operand_b),
    .result (b_mag)
  );

  muldiv_unit_twos_negate #(.width(2*data_width)) u_fix_prod (
    .negate (neg_lo_q),
    .value  (acc_q),
    .result (prod_fix)
  );

  muldiv_unit_twos_negate #(.width(data_width)) u_fix_quot (
    .negate (neg_lo_q),
    .value  (acc_q[data_width-1:0]),
    .result (quot_fix)
  );

  muldiv_unit_twos_negate #(.width(data_width)) u_fix_rem (
    .negate (neg_hi_q),
    .value  (acc_q[2*data_width-1:data_width]),
    .result (rem_fix)
  );

  // Datapath step terms: shift-add carry-out and restoring trial subtract.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*data_width-1:data_width]} + {1'b0, opnd_q};
    div_rem  = acc_q[2*data_width-1:data_width-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_ok   = ~div_diff[data_width];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hilo_write) begin
          if (hilo_sel) hi_d = hilo_write_data;
          else          lo_d = hilo_write_data;
        end
        if (start) begin
          count_d    = '0;
          is_div_d   = div_op;
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = a_neg;
          div_zero_d = (operand_b == '0);
          if (div_op) begin
            acc_d   = {{data_width{1'b0}}, a_mag};
            opnd_d  = b_mag;
            state_d = ST_DIV;
          end else begin
            acc_d   = {{data_width{1'b0}}, b_mag};
            opnd_d  = a_mag;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        acc_d   = acc_q[0] ? {mul_sum, acc_q[data_width-1:1]}
                           : {1'b0, acc_q[2*data_width-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == {count_width{1'b1}}) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d   = div_ok ? {div_diff[data_width-1:0], acc_q[data_width-2:0], 1'b1}
                         : {acc_q[2*data_width-2:0], 1'b0};
        count_d = count_q + 1'b1;
        if (count_q == {count_width{1'b1}}) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          // Divide by zero leaves |a| as remainder, so rem_fix restores a exactly.
          lo_d = div_zero_q ? {data_width{1'b1}} : quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and working registers; reset aborts any op in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
